mc_sequencer: RTL and testbench

- Multi-cycle control sequencer for the MIPS core. Replaces single-cycle decode with a registered FSM.
- Steps each instruction through fetch, decode, execute, memory and writeback over a single shared memory port, using a req/ready handshake.
- Drives the datapath mux selects, write enables and the 5-bit ALU operation code.
- Detects illegal opcodes and memory timeouts, then parks in a sticky fault state.

---
 rtl/mips_pkg.sv | 82 ++++++++
 rtl/mc_sequencer_if.sv | 36 +++
 rtl/mc_output_decode.sv | 81 ++++++++
 rtl/mc_sequencer.sv | 95 +++++++++
 tb/tb_mc_sequencer.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, ALU op
// codes, sequencer state encoding and the datapath select encodings.
package mips_pkg;

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      EXEC_R    = 4'd6,
      R_WB      = 4'd7,
      EXEC_I    = 4'd8,
      I_WB      = 4'd9,
      BRANCH    = 4'd10,
      JUMP      = 4'd11,
      FAULT     = 4'd12
   } stateT;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SEQ   = 6'b011000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [4:0] ALU_ADD    = 5'b00000;
   localparam logic [4:0] ALU_RFUNCT = 5'b00010;
   localparam logic [4:0] ALU_ADDI   = 5'b00011;
   localparam logic [4:0] ALU_AND    = 5'b00100;
   localparam logic [4:0] ALU_OR     = 5'b00101;
   localparam logic [4:0] ALU_XOR    = 5'b00110;
   localparam logic [4:0] ALU_SLT    = 5'b00111;
   localparam logic [4:0] ALU_SUB    = 5'b01000;
   localparam logic [4:0] ALU_SEQ    = 5'b01001;
   localparam logic [4:0] ALU_NOP    = 5'b01111;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_RT    = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   typedef struct packed {
      logic       memReq;
      logic       memWe;
      logic       iOrD;
      logic       irWrite;
      logic       pcWrite;
      logic       pcWriteCond;
      logic [1:0] pcSrc;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [4:0] aluOp;
      logic       regDst;
      logic       regWrite;
      logic       memToReg;
      logic       fault;
   } ctrlT;

   function automatic logic [4:0] iTypeAluOp(input logic [5:0] op);
      case (op)
         OP_ADDI: return ALU_ADDI;
         OP_ANDI: return ALU_AND;
         OP_ORI:  return ALU_OR;
         OP_XORI: return ALU_XOR;
         OP_SLTI: return ALU_SLT;
         OP_SEQ:  return ALU_SEQ;
         default: return ALU_NOP;
      endcase
   endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Sequencer-to-datapath/memory signal bundle; master is the sequencer side.
interface mc_sequencer_if;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       mem_req;
   logic       mem_we;
   logic       i_or_d;
   logic       ir_write;
   logic       pc_write;
   logic       pc_write_cond;
   logic [1:0] pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [4:0] alu_op;
   logic       reg_dst;
   logic       reg_write;
   logic       mem_to_reg;
   logic       retire;
   logic       fault;
   logic [3:0] state;

   modport master (
      input  opcode, zero, mem_ready,
      output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
             alu_src_a, alu_src_b, alu_op, reg_dst, reg_write, mem_to_reg,
             retire, fault, state
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
             alu_src_a, alu_src_b, alu_op, reg_dst, reg_write, mem_to_reg,
             retire, fault, state
   );
endinterface

// File: rtl/mc_output_decode.sv
// Moore control decode: sequencer state (plus opcode for the I-type ALU op and
// mem_ready for the fetch strobes) to the datapath control vector.
module mc_output_decode
   import mips_pkg::*;
(
   input  stateT      state,
   input  logic [5:0] opcode,
   input  logic       memReady,
   output ctrlT       ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.memReq  = 1'b1;
            ctrl.aluSrcB = SRCB_FOUR;
            ctrl.aluOp   = ALU_ADD;
            ctrl.pcSrc   = PC_ALU;
            ctrl.irWrite = memReady;
            ctrl.pcWrite = memReady;
         end
         DECODE: begin
            ctrl.aluSrcB = SRCB_IMMSH;
            ctrl.aluOp   = ALU_ADD;
         end
         MEM_ADDR: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = ALU_ADD;
         end
         MEM_READ: begin
            ctrl.memReq = 1'b1;
            ctrl.iOrD   = 1'b1;
         end
         MEM_WB: begin
            ctrl.regWrite = 1'b1;
            ctrl.memToReg = 1'b1;
         end
         MEM_WRITE: begin
            ctrl.memReq = 1'b1;
            ctrl.memWe  = 1'b1;
            ctrl.iOrD   = 1'b1;
         end
         EXEC_R: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_RT;
            ctrl.aluOp   = ALU_RFUNCT;
         end
         R_WB: begin
            ctrl.regWrite = 1'b1;
            ctrl.regDst   = 1'b1;
         end
         EXEC_I: begin
            ctrl.aluSrcA = 1'b1;
            ctrl.aluSrcB = SRCB_IMM;
            ctrl.aluOp   = iTypeAluOp(opcode);
         end
         I_WB: begin
            ctrl.regWrite = 1'b1;
         end
         BRANCH: begin
            ctrl.aluSrcA     = 1'b1;
            ctrl.aluSrcB     = SRCB_RT;
            ctrl.aluOp       = ALU_SUB;
            ctrl.pcWriteCond = 1'b1;
            ctrl.pcSrc       = PC_ALUOUT;
         end
         JUMP: begin
            ctrl.pcWrite = 1'b1;
            ctrl.pcSrc   = PC_JUMP;
         end
         FAULT: begin
            ctrl.fault = 1'b1;
            ctrl.aluOp = ALU_NOP;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS control sequencer: state register, memory wait counter with
// timeout fault, and the registered retire pulse.
module mc_sequencer
   import mips_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 8
) (
   input logic           clk,
   input logic           rst_n,
   mc_sequencer_if.master bus
);

   stateT            state;
   stateT            nextState;
   logic [CNT_W-1:0] waitCnt;
   logic             retireQ;
   logic             timeout;
   ctrlT             ctrl;

   mc_output_decode uDecode (
      .state    (state),
      .opcode   (bus.opcode),
      .memReady (bus.mem_ready),
      .ctrl     (ctrl)
   );

   // mem_ready on the timeout cycle still completes the access.
   assign timeout = ctrl.memReq && !bus.mem_ready && (waitCnt == CNT_W'(MEM_TIMEOUT));

   always_comb begin
      nextState = state;
      case (state)
         FETCH:     if (timeout) nextState = FAULT;
                    else if (bus.mem_ready) nextState = DECODE;
         DECODE: begin
            case (bus.opcode)
               OP_RTYPE:                  nextState = EXEC_R;
               OP_LW, OP_SW:              nextState = MEM_ADDR;
               OP_ADDI, OP_ANDI, OP_ORI,
               OP_XORI, OP_SLTI, OP_SEQ:  nextState = EXEC_I;
               OP_BEQ:                    nextState = BRANCH;
               OP_J:                      nextState = JUMP;
               default:                   nextState = FAULT;
            endcase
         end
         MEM_ADDR:  nextState = (bus.opcode == OP_LW) ? MEM_READ :
                                (bus.opcode == OP_SW) ? MEM_WRITE : FAULT;
         MEM_READ:  if (timeout) nextState = FAULT;
                    else if (bus.mem_ready) nextState = MEM_WB;
         MEM_WRITE: if (timeout) nextState = FAULT;
                    else if (bus.mem_ready) nextState = FETCH;
         MEM_WB, R_WB, I_WB, BRANCH, JUMP: nextState = FETCH;
         EXEC_R:    nextState = R_WB;
         EXEC_I:    nextState = I_WB;
         FAULT:     nextState = FAULT;
         default:   nextState = FAULT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= FETCH;
         waitCnt <= '0;
         retireQ <= 1'b0;
      end else begin
         state   <= nextState;
         // Every path back into FETCH (other than from FETCH itself) completes an instruction.
         retireQ <= (nextState == FETCH) && (state != FETCH);
         if (nextState != state || bus.mem_ready || !ctrl.memReq)
            waitCnt <= '0;
         else
            waitCnt <= waitCnt + CNT_W'(1);
      end
   end

   // Fetch strobes follow mem_ready combinationally, so they are held off during reset.
   assign bus.mem_req       = ctrl.memReq;
   assign bus.mem_we        = ctrl.memWe;
   assign bus.i_or_d        = ctrl.iOrD;
   assign bus.ir_write      = ctrl.irWrite & rst_n;
   assign bus.pc_write      = ctrl.pcWrite & rst_n;
   assign bus.pc_write_cond = ctrl.pcWriteCond;
   assign bus.pc_src        = ctrl.pcSrc;
   assign bus.alu_src_a     = ctrl.aluSrcA;
   assign bus.alu_src_b     = ctrl.aluSrcB;
   assign bus.alu_op        = ctrl.aluOp;
   assign bus.reg_dst       = ctrl.regDst;
   assign bus.reg_write     = ctrl.regWrite;
   assign bus.mem_to_reg    = ctrl.memToReg;
   assign bus.fault         = ctrl.fault;
   assign bus.retire        = retireQ;
   assign bus.state         = state;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed-vector bench for mc_sequencer; expected values are hand-derived.
module tb_mc_sequencer;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   mc_sequencer_if bus();

   mc_sequencer #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      bus.opcode = 6'd0;
      bus.zero = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.mem_ready = 1'b1;
      #1;
      vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
      vectors++; if (bus.retire !== 1'b0) begin miscompares++; $display("FAIL reset_retire got=%b exp=0", bus.retire); end
      vectors++; if (bus.fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got=%b exp=0", bus.fault); end
      vectors++; if (bus.mem_req !== 1'b1) begin miscompares++; $display("FAIL reset_mem_req got=%b exp=1", bus.mem_req); end
      vectors++; if ({bus.ir_write, bus.pc_write, bus.reg_write} !== 3'b000) begin miscompares++; $display("FAIL reset_enables got=%b exp=000", {bus.ir_write, bus.pc_write, bus.reg_write}); end
      tick();
      vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL reset_hold_state got=%0d exp=0", bus.state); end
      rst_n = 1'b1;
   endtask

   task automatic test_rtype();
      int expS[5] = '{0, 1, 6, 7, 0};
      int expR[5] = '{0, 0, 0, 0, 1};
      apply_reset();
      bus.opcode = OP_RTYPE;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++; if (bus.state !== 4'(expS[i])) begin miscompares++; $display("FAIL rtype_state[%0d] got=%0d exp=%0d", i, bus.state, expS[i]); end
         vectors++; if (bus.retire !== 1'(expR[i])) begin miscompares++; $display("FAIL rtype_retire[%0d] got=%b exp=%0d", i, bus.retire, expR[i]); end
         if (i == 2) begin
            vectors++; if (bus.alu_op !== 5'b00010) begin miscompares++; $display("FAIL rtype_alu_op got=%b exp=00010", bus.alu_op); end
         end
         if (i == 3) begin
            vectors++; if ({bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 3'b110) begin miscompares++; $display("FAIL rtype_wb got=%b exp=110", {bus.reg_write, bus.reg_dst, bus.mem_to_reg}); end
         end
         tick();
      end
   endtask

   task automatic test_lw_wait();
      int rdy[9]  = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
      int expS[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
      int req[9]  = '{1, 0, 0, 1, 1, 1, 1, 0, 1};
      int iod[9]  = '{0, 0, 0, 1, 1, 1, 1, 0, 0};
      int ret[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
      apply_reset();
      bus.opcode = OP_LW;
      for (int i = 0; i < 9; i++) begin
         bus.mem_ready = 1'(rdy[i]);
         #1;
         vectors++; if (bus.state !== 4'(expS[i])) begin miscompares++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, bus.state, expS[i]); end
         vectors++; if ({bus.mem_req, bus.i_or_d} !== {1'(req[i]), 1'(iod[i])}) begin miscompares++; $display("FAIL lw_req_iord[%0d] got=%b exp=%0d%0d", i, {bus.mem_req, bus.i_or_d}, req[i], iod[i]); end
         vectors++; if (bus.retire !== 1'(ret[i])) begin miscompares++; $display("FAIL lw_retire[%0d] got=%b exp=%0d", i, bus.retire, ret[i]); end
         if (i == 7) begin
            vectors++; if ({bus.reg_write, bus.mem_to_reg, bus.reg_dst} !== 3'b110) begin miscompares++; $display("FAIL lw_wb got=%b exp=110", {bus.reg_write, bus.mem_to_reg, bus.reg_dst}); end
         end
         tick();
      end
   endtask

   task automatic test_sw();
      int expS[5] = '{0, 1, 2, 5, 0};
      apply_reset();
      bus.opcode = OP_SW;
      bus.mem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++; if (bus.state !== 4'(expS[i])) begin miscompares++; $display("FAIL sw_state[%0d] got=%0d exp=%0d", i, bus.state, expS[i]); end
         if (i == 3) begin
            vectors++; if ({bus.mem_req, bus.mem_we, bus.i_or_d} !== 3'b111) begin miscompares++; $display("FAIL sw_mem got=%b exp=111", {bus.mem_req, bus.mem_we, bus.i_or_d}); end
         end
         if (i == 4) begin
            vectors++; if (bus.retire !== 1'b1) begin miscompares++; $display("FAIL sw_retire got=%b exp=1", bus.retire); end
         end
         tick();
      end
   endtask

   task automatic test_itype();
      logic [5:0] ops[6] = '{6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010, 6'b011000};
      logic [4:0] alu[6] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01001};
      apply_reset();
      bus.mem_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         bus.opcode = ops[k];
         #1;
         vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL itype_fetch[%0d] got=%0d exp=0", k, bus.state); end
         tick(); tick(); #1;
         vectors++; if (bus.state !== 4'd8) begin miscompares++; $display("FAIL itype_exec[%0d] got=%0d exp=8", k, bus.state); end
         vectors++; if (bus.alu_op !== alu[k]) begin miscompares++; $display("FAIL itype_alu_op[%0d] got=%b exp=%b", k, bus.alu_op, alu[k]); end
         vectors++; if ({bus.alu_src_a, bus.alu_src_b} !== 3'b110) begin miscompares++; $display("FAIL itype_src[%0d] got=%b exp=110", k, {bus.alu_src_a, bus.alu_src_b}); end
         tick(); #1;
         vectors++; if ({bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== {4'd9, 3'b100}) begin miscompares++; $display("FAIL itype_wb[%0d] got=%b exp=1001100", k, {bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg}); end
         tick(); #1;
         vectors++; if (bus.retire !== 1'b1) begin miscompares++; $display("FAIL itype_retire[%0d] got=%b exp=1", k, bus.retire); end
      end
   endtask

   task automatic test_illegal();
      apply_reset();
      bus.opcode = 6'b111111;
      bus.mem_ready = 1'b1;
      tick(); tick(); #1;
      vectors++; if (bus.state !== 4'd12) begin miscompares++; $display("FAIL illegal_state got=%0d exp=12", bus.state); end
      for (int i = 0; i < 20; i++) begin
         tick(); #1;
         vectors++; if ({bus.state, bus.fault, bus.retire} !== {4'd12, 2'b10}) begin miscompares++; $display("FAIL illegal_sticky[%0d] got=%b exp=110010", i, {bus.state, bus.fault, bus.retire}); end
         vectors++; if ({bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.reg_write} !== 6'b0) begin miscompares++; $display("FAIL illegal_enables[%0d] got=%b exp=000000", i, {bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write, bus.pc_write_cond, bus.reg_write}); end
         vectors++; if (bus.alu_op !== 5'b01111) begin miscompares++; $display("FAIL illegal_alu_op[%0d] got=%b exp=01111", i, bus.alu_op); end
      end
      rst_n = 1'b0;
      #1;
      vectors++; if ({bus.state, bus.fault} !== 5'b00000) begin miscompares++; $display("FAIL illegal_clear got=%b exp=00000", {bus.state, bus.fault}); end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_timeout();
      apply_reset();
      bus.opcode = OP_RTYPE;
      for (int i = 0; i < 16; i++) begin
         #1;
         vectors++; if ({bus.state, bus.mem_req, bus.i_or_d, bus.ir_write} !== {4'd0, 3'b100}) begin miscompares++; $display("FAIL timeout_wait[%0d] got=%b exp=0000100", i, {bus.state, bus.mem_req, bus.i_or_d, bus.ir_write}); end
         tick();
      end
      #1;
      vectors++; if ({bus.state, bus.fault} !== {4'd12, 1'b1}) begin miscompares++; $display("FAIL timeout_fault got=%b exp=11001", {bus.state, bus.fault}); end
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         bus.mem_ready = (i == 15);
         #1;
         vectors++; if (bus.state !== 4'd0) begin miscompares++; $display("FAIL timeout_edge_wait[%0d] got=%0d exp=0", i, bus.state); end
         tick();
      end
      #1;
      vectors++; if ({bus.state, bus.fault} !== {4'd1, 1'b0}) begin miscompares++; $display("FAIL timeout_edge_ready got=%b exp=00010", {bus.state, bus.fault}); end
   endtask

   task automatic test_branch_jump();
      apply_reset();
      bus.opcode = OP_BEQ;
      bus.zero = 1'b1;
      bus.mem_ready = 1'b1;
      tick(); tick(); #1;
      vectors++; if (bus.state !== 4'd10) begin miscompares++; $display("FAIL beq_state got=%0d exp=10", bus.state); end
      vectors++; if ({bus.pc_write_cond, bus.pc_src, bus.alu_op} !== {1'b1, 2'b01, 5'b01000}) begin miscompares++; $display("FAIL beq_ctrl got=%b exp=10101000", {bus.pc_write_cond, bus.pc_src, bus.alu_op}); end
      tick();
      bus.opcode = OP_J;
      #1;
      vectors++; if ({bus.state, bus.retire} !== {4'd0, 1'b1}) begin miscompares++; $display("FAIL beq_retire got=%b exp=00001", {bus.state, bus.retire}); end
      tick(); tick(); #1;
      vectors++; if ({bus.state, bus.pc_write, bus.pc_src} !== {4'd11, 1'b1, 2'b10}) begin miscompares++; $display("FAIL jump_ctrl got=%b exp=1011110", {bus.state, bus.pc_write, bus.pc_src}); end
      tick(); #1;
      vectors++; if ({bus.state, bus.retire} !== {4'd0, 1'b1}) begin miscompares++; $display("FAIL jump_retire got=%b exp=00001", {bus.state, bus.retire}); end
      bus.zero = 1'b0;
   endtask

   task automatic test_reset_mid();
      apply_reset();
      bus.opcode = OP_RTYPE;
      bus.mem_ready = 1'b1;
      tick(); tick(); #1;
      vectors++; if (bus.state !== 4'd6) begin miscompares++; $display("FAIL mid_exec got=%0d exp=6", bus.state); end
      #1;
      rst_n = 1'b0;
      #1;
      vectors++; if ({bus.state, bus.retire, bus.reg_write, bus.ir_write, bus.pc_write} !== 8'b0) begin miscompares++; $display("FAIL mid_reset got=%b exp=00000000", {bus.state, bus.retire, bus.reg_write, bus.ir_write, bus.pc_write}); end
      tick(); #1;
      vectors++; if ({bus.state, bus.retire} !== 5'b0) begin miscompares++; $display("FAIL mid_hold got=%b exp=00000", {bus.state, bus.retire}); end
      rst_n = 1'b1;
      tick(); #1;
      vectors++; if ({bus.state, bus.retire} !== {4'd1, 1'b0}) begin miscompares++; $display("FAIL mid_restart got=%b exp=00010", {bus.state, bus.retire}); end
   endtask

   initial begin
      rst_n = 1'b0;
      bus.opcode = 6'd0;
      bus.zero = 1'b0;
      bus.mem_ready = 1'b0;
      tick();
      test_reset();
      test_rtype();
      test_lw_wait();
      test_sw();
      test_itype();
      test_illegal();
      test_timeout();
      test_branch_jump();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
